// File: rtl/routex_egress.sv
// routex_egress: strips routex header flits and buffers payload flits onto a valid/ready stream
module routex_egress #(
  parameter int Depth  = 16,
  parameter int BpSkid = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [7:0][63:0] Q,
  input  logic            Q_VALID,
  input  logic            Q_SOF,
  output logic            Q_BP,
  output logic [7:0][63:0] M_DATA,
  output logic            M_VALID,
  input  logic            M_READY,
  output logic            M_SOP,
  output logic            M_EOP,
  output logic [7:0]      M_KEEP,
  output logic [31:0]     M_LEN,
  input  logic            ERR_CLR,
  output logic            ERR_OVF,
  output logic            ERR_PROTO
);
  localparam int AW = $clog2(Depth);
  typedef enum logic {IDLE, PAYLOAD} state_t;
  typedef struct packed {
    logic [7:0][63:0] data;
    logic             sop;
    logic             eop;
    logic [7:0]       keep;
    logic [31:0]      len;
  } ent_t;
  state_t state, state_n;
  logic [31:0] rem, rem_n, len, len_n;
  logic first, first_n, push, proto, hdr, pld, hdr_ok, hdr_go, last;
  logic pop, full, wr, ovf;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count, count_n;
  ent_t ent, head;
  ent_t mem [Depth];
  assign hdr    = Q_VALID & Q_SOF;
  assign pld    = Q_VALID & ~Q_SOF;
  assign hdr_ok = Q[7][63:56] == 8'd0;
  assign hdr_go = hdr_ok & (Q[7][31:0] != 32'd0);
  assign last   = rem <= 32'd8;
  // Header parsing, payload tagging and protocol checking
  always_comb begin
    state_n   = state;
    rem_n     = rem;
    len_n     = len;
    first_n   = first;
    push      = 1'b0;
    proto     = 1'b0;
    ent.data  = Q;
    ent.sop   = first;
    ent.eop   = 1'b0;
    ent.keep  = 8'hFF;
    ent.len   = len;
    if (hdr) begin
      proto   = (state == PAYLOAD) | ~hdr_ok;
      state_n = hdr_go ? PAYLOAD : IDLE;
      rem_n   = hdr_go ? Q[7][31:0] : rem;
      len_n   = hdr_go ? Q[7][31:0] : len;
      first_n = hdr_go | first;
    end else if (pld) begin
      proto    = state == IDLE;
      push     = state == PAYLOAD;
      first_n  = (state == PAYLOAD) ? 1'b0 : first;
      ent.eop  = last;
      ent.keep = last ? 8'hFF >> (4'd8 - rem[3:0]) : 8'hFF;
      rem_n    = (state == PAYLOAD) ? (last ? 32'd0 : rem - 32'd8) : rem;
      state_n  = (state == PAYLOAD && last) ? IDLE : state;
    end
  end
  // Packet tracking state
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      rem   <= '0;
      len   <= '0;
      first <= 1'b0;
    end else begin
      state <= state_n;
      rem   <= rem_n;
      len   <= len_n;
      first <= first_n;
    end
  end
  assign pop     = (count != '0) & M_READY;
  assign full    = count == (AW+1)'(Depth);
  assign wr      = push & (~full | pop);
  assign ovf     = push & full & ~pop;
  assign count_n = count + (AW+1)'(wr) - (AW+1)'(pop);
  // Payload storage, no reset needed since occupancy gates visibility
  always_ff @(posedge CLK) begin
    if (wr) mem[wr_ptr] <= ent;
  end
  // FIFO pointers, back pressure and sticky error flags
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      Q_BP      <= 1'b0;
      ERR_OVF   <= 1'b0;
      ERR_PROTO <= 1'b0;
    end else begin
      wr_ptr    <= wr ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr    <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count     <= count_n;
      Q_BP      <= count_n >= (AW+1)'(Depth - BpSkid);
      ERR_OVF   <= ovf | (ERR_OVF & ~ERR_CLR);
      ERR_PROTO <= proto | (ERR_PROTO & ~ERR_CLR);
    end
  end
  assign head    = mem[rd_ptr];
  assign M_VALID = count != '0;
  assign M_DATA  = head.data;
  assign M_SOP   = head.sop;
  assign M_EOP   = head.eop;
  assign M_KEEP  = head.keep;
  assign M_LEN   = head.len;
endmodule
